// File: rtl/median_filter_ctrl.sv
// Sequencing controller for the 1x15 median stage: matched-latency bypass, frame-aligned
// filter enable, frame/white-pixel statistics and an Avalon-MM register window.
module median_filter_ctrl #(
  parameter int LATENCY = 15,
  parameter int HSYNC_W = 10,
  parameter int PIX_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               irq,
  input  logic               Cam_enable_in,
  input  logic [HSYNC_W-1:0] CamHsync_count_in,
  input  logic [PIX_W-1:0]   CamPix_count_in,
  input  logic [15:0]        data_in,
  output logic [15:0]        med_data_in,
  input  logic               med_enable_out,
  input  logic [HSYNC_W-1:0] med_hsync_out,
  input  logic [PIX_W-1:0]   med_pix_out,
  input  logic [15:0]        med_data_out,
  output logic               Cam_enable_out,
  output logic [HSYNC_W-1:0] CamHsync_count_out,
  output logic [PIX_W-1:0]   CamPix_count_out,
  output logic [15:0]        data_out
);

  // state   | meaning
  // OFF     | bypass selected, filter not requested
  // ARM_ON  | filter requested, still bypassing until next start of frame
  // ON      | filter output selected
  // ARM_OFF | filter released, still filtering until next start of frame
  localparam logic [1:0] S_OFF     = 2'd0;
  localparam logic [1:0] S_ARM_ON  = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_ARM_OFF = 2'd3;

  logic [1:0]  state, next_state;
  logic [15:0] pipe [LATENCY];
  logic [1:0]  ctrl;
  logic        frame_done, seen_frame;
  logic [15:0] frame_count;
  logic [20:0] white_count, pix_cnt;
  logic        sof, filter_sel, white, frame_set;
  logic        wr_ctrl, wr_status, wr_fcount;
  logic        unused_bits;

  assign unused_bits = ^{avs_read, avs_writedata[31:3], Cam_enable_in,
                         CamHsync_count_in, CamPix_count_in};

  assign med_data_in        = data_in;
  assign Cam_enable_out     = med_enable_out;
  assign CamHsync_count_out = med_hsync_out;
  assign CamPix_count_out   = med_pix_out;

  assign sof = med_enable_out && (med_hsync_out == '0) && (med_pix_out == '0);

  always_comb begin
    next_state = state;
    case (state)
      S_OFF:     if (ctrl[0]) next_state = S_ARM_ON;
      S_ARM_ON:  if (!ctrl[0]) next_state = S_OFF;
                 else if (sof) next_state = S_ON;
      S_ON:      if (!ctrl[0]) next_state = S_ARM_OFF;
      S_ARM_OFF: if (ctrl[0]) next_state = S_ON;
                 else if (sof) next_state = S_OFF;
      default:   next_state = S_OFF;
    endcase
  end

  // On the sof pixel the mux already follows the state being entered.
  always_comb begin
    filter_sel = (state == S_ON) || (state == S_ARM_OFF);
    if (sof) filter_sel = (next_state == S_ON) || (next_state == S_ARM_OFF);
  end

  assign data_out  = filter_sel ? med_data_out : pipe[LATENCY-1];
  assign white     = med_enable_out && (data_out == 16'hffff);
  assign frame_set = sof && seen_frame;

  assign wr_ctrl   = avs_write && (avs_address == 2'd0);
  assign wr_status = avs_write && (avs_address == 2'd1);
  assign wr_fcount = avs_write && (avs_address == 2'd2);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= data_in;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_OFF;
      ctrl        <= '0;
      frame_done  <= 1'b0;
      seen_frame  <= 1'b0;
      frame_count <= '0;
      white_count <= '0;
      pix_cnt     <= '0;
      irq         <= 1'b0;
    end else begin
      state <= next_state;
      if (wr_ctrl) ctrl <= avs_writedata[1:0];

      if (sof) pix_cnt <= 21'(white);
      else if (white) pix_cnt <= pix_cnt + 21'd1;

      if (sof) seen_frame <= 1'b1;
      if (frame_set) white_count <= pix_cnt;

      if (wr_fcount) frame_count <= '0;
      else if (frame_set) frame_count <= frame_count + 16'd1;

      // A frame completing in the same cycle as a clear keeps the flag set.
      if (frame_set) frame_done <= 1'b1;
      else if (wr_status && avs_writedata[2]) frame_done <= 1'b0;

      irq <= frame_done & ctrl[1];
    end
  end

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      2'd0: avs_readdata = {30'b0, ctrl};
      2'd1: avs_readdata = {29'b0, frame_done,
                            (state == S_ARM_ON) || (state == S_ARM_OFF),
                            (state == S_ON) || (state == S_ARM_OFF)};
      2'd2: avs_readdata = {16'b0, frame_count};
      default: avs_readdata = {11'b0, white_count};
    endcase
  end

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Bench for median_filter_ctrl: emulates the 15-clock median stage, keeps a frame-level
// reference model, and runs a directed op table plus randomized frames.
module tb_median_filter_ctrl;
  localparam int LAT = 15;
  localparam int HW  = 10;
  localparam int PW  = 11;

  localparam int K_WR = 0, K_RDM = 1, K_RDC = 2, K_SIG = 3, K_RST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    avs_address;
  logic          avs_read, avs_write;
  logic [31:0]   avs_writedata, avs_readdata;
  logic          irq;
  logic          cam_en_in;
  logic [HW-1:0] cam_hs_in;
  logic [PW-1:0] cam_pix_in;
  logic [15:0]   data_in, med_data_in;
  logic          med_en;
  logic [HW-1:0] med_hs;
  logic [PW-1:0] med_pix;
  logic [15:0]   med_data, raw_d;
  logic          cam_en_out;
  logic [HW-1:0] cam_hs_out;
  logic [PW-1:0] cam_pix_out;
  logic [15:0]   data_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  median_filter_ctrl #(.LATENCY(LAT), .HSYNC_W(HW), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
    .Cam_enable_in(cam_en_in), .CamHsync_count_in(cam_hs_in), .CamPix_count_in(cam_pix_in),
    .data_in(data_in), .med_data_in(med_data_in),
    .med_enable_out(med_en), .med_hsync_out(med_hs), .med_pix_out(med_pix),
    .med_data_out(med_data),
    .Cam_enable_out(cam_en_out), .CamHsync_count_out(cam_hs_out),
    .CamPix_count_out(cam_pix_out), .data_out(data_out)
  );

  typedef struct packed {
    logic          en;
    logic [HW-1:0] hs;
    logic [PW-1:0] pix;
    logic [15:0]   d;
  } cam_t;

  typedef struct {
    int          frame;
    int          off;
    int          kind;
    logic [1:0]  addr;
    logic [31:0] val;
    string       name;
  } op_t;

  cam_t hist [64];
  int   k;
  op_t  dir_tab [$];
  op_t  ops [$];
  int   kinds [14] = '{0, 0, 0, 1, 1, 1, 1, 0, 2, 3, 3, 1, 0, 0};

  // Reference model: filter mode is one bit that follows the request at each start of frame.
  logic [1:0]  ctrl_m;
  logic        mode, seen, fdone, irq_m;
  logic [15:0] fcount;
  logic [20:0] wcount, pcnt;

  function automatic logic [15:0] med_fn(input logic [15:0] d);
    return (d >= 16'h8000) ? 16'hffff : 16'h0000;
  endfunction

  function automatic logic sof_now();
    return med_en && (med_hs == '0) && (med_pix == '0);
  endfunction

  function automatic logic [15:0] exp_dout();
    logic m;
    m = sof_now() ? ctrl_m[0] : mode;
    return m ? med_data : raw_d;
  endfunction

  function automatic logic [31:0] reg_model(input logic [1:0] a);
    case (a)
      2'd0:    return {30'b0, ctrl_m};
      2'd1:    return {29'b0, fdone, ctrl_m[0] ^ mode, mode};
      2'd2:    return {16'b0, fcount};
      default: return {11'b0, wcount};
    endcase
  endfunction

  // Median stage emulation (delay LAT) and the model, both advanced on the falling edge.
  always @(negedge clk or posedge reset) begin : mdl
    logic        s, m, w, fset;
    logic [15:0] dexp;
    cam_t        h;
    if (reset) begin
      k = 0;
      med_en <= 1'b0; med_hs <= '0; med_pix <= '0; med_data <= '0; raw_d <= '0;
      ctrl_m = '0; mode = 1'b0; seen = 1'b0; fdone = 1'b0; irq_m = 1'b0;
      fcount = '0; wcount = '0; pcnt = '0;
    end else begin
      s    = sof_now();
      m    = s ? ctrl_m[0] : mode;
      dexp = m ? med_data : raw_d;
      w    = med_en && (dexp == 16'hffff);
      fset = s && seen;
      irq_m = fdone & ctrl_m[1];
      if (s) begin
        if (seen) begin wcount = pcnt; fcount = fcount + 16'd1; end
        seen = 1'b1;
        pcnt = 21'(w);
      end else if (w) pcnt = pcnt + 21'd1;
      if (avs_write) begin
        case (avs_address)
          2'd0: ctrl_m = avs_writedata[1:0];
          2'd1: if (avs_writedata[2]) fdone = 1'b0;
          2'd2: fcount = '0;
          default: ;
        endcase
      end
      if (fset) fdone = 1'b1;
      mode = m;
      k = k + 1;
      hist[k % 64] = {cam_en_in, cam_hs_in, cam_pix_in, data_in};
      if (k >= LAT) begin
        h = hist[(k - LAT + 1) % 64];
        med_en <= h.en; med_hs <= h.hs; med_pix <= h.pix;
        med_data <= med_fn(h.d); raw_d <= h.d;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic en, input logic [HW-1:0] hs, input logic [PW-1:0] pix,
                      input logic [15:0] d);
    @(posedge clk); #1;
    chk("data_out", {16'b0, data_out}, {16'b0, exp_dout()});
    chk("irq", {31'b0, irq}, {31'b0, irq_m});
    chk("cam_en_out", {31'b0, cam_en_out}, {31'b0, med_en});
    chk("med_data_in", {16'b0, med_data_in}, {16'b0, data_in});
    cam_en_in = en; cam_hs_in = hs; cam_pix_in = pix; data_in = d;
    avs_write = 1'b0; avs_read = 1'b0;
  endtask

  task automatic do_op(input op_t p);
    case (p.kind)
      K_WR: begin avs_write = 1'b1; avs_address = p.addr; avs_writedata = p.val; end
      K_RDM: begin
        avs_read = 1'b1; avs_address = p.addr; #1;
        chk(p.name, avs_readdata, reg_model(p.addr));
      end
      K_RDC: begin
        avs_read = 1'b1; avs_address = p.addr; #1;
        chk(p.name, avs_readdata, p.val);
      end
      K_SIG: begin
        if (p.addr == 2'd0) chk(p.name, {16'b0, data_out}, p.val);
        else chk(p.name, {31'b0, irq}, p.val);
      end
      default: begin
        reset = 1'b1; #1;
        for (int a = 0; a < 4; a++) begin
          avs_address = 2'(a); #1;
          chk("rst_mid_reg", avs_readdata, 32'h0);
        end
        chk("rst_mid_irq", {31'b0, irq}, 32'h0);
        chk("rst_mid_dout", {16'b0, data_out}, 32'h0);
        chk("rst_mid_en", {31'b0, cam_en_out}, 32'h0);
        #1 reset = 1'b0;
      end
    endcase
  endtask

  // 4 lines of 4 pixels, 2 blank clocks per line, 4 blank clocks at frame end.
  task automatic frame(input int kind);
    int line, col;
    logic en;
    logic [15:0] d;
    for (int o = 0; o < 28; o++) begin
      line = o / 6;
      col  = o % 6;
      en   = (o < 24) && (col < 4);
      case (kind)
        0:       d = 16'h1234;
        1:       d = 16'($urandom);
        2:       d = (line * 4 + col < 7) ? 16'hf000 : 16'h0100;
        default: d = 16'h0100;
      endcase
      if (!en) d = '0;
      tick(en, HW'(line), PW'(col), d);
      foreach (ops[i]) if (ops[i].off == o) do_op(ops[i]);
    end
    ops.delete();
  endtask

  function automatic void add(input int f, input int off, input int kind, input logic [1:0] addr,
                              input logic [31:0] val, input string name);
    op_t p;
    p.frame = f; p.off = off; p.kind = kind; p.addr = addr; p.val = val; p.name = name;
    dir_tab.push_back(p);
  endfunction

  function automatic void add_rand(input int off, input int kind, input logic [1:0] addr,
                                   input logic [31:0] val, input string name);
    op_t p;
    p.frame = -1; p.off = off; p.kind = kind; p.addr = addr; p.val = val; p.name = name;
    ops.push_back(p);
  endfunction

  initial begin
    add(2,  15, K_SIG, 0, 32'h1234, "bypass_lat15");
    add(2,  19, K_SIG, 0, 32'h0,    "bypass_blank");
    add(2,  20, K_RDC, 2, 32'd2,    "fcount_3frames");
    add(2,  20, K_RDC, 1, 32'h4,    "status_3frames");
    add(3,   3, K_WR,  0, 32'h1,    "");
    add(3,   8, K_RDC, 1, 32'h6,    "status_arm_on");
    add(3,  20, K_RDC, 1, 32'h5,    "status_on");
    add(4,  22, K_WR,  0, 32'h0,    "");
    add(4,  25, K_RDC, 1, 32'h7,    "status_arm_off");
    add(5,  18, K_WR,  0, 32'h1,    "");
    add(5,  22, K_WR,  0, 32'h0,    "");
    add(5,  25, K_RDC, 1, 32'h4,    "status_cancel");
    add(6,  20, K_RDC, 1, 32'h4,    "status_no_switch");
    add(7,   3, K_WR,  0, 32'h3,    "");
    add(8,  20, K_WR,  1, 32'h4,    "");
    add(8,  24, K_RDC, 1, 32'h1,    "status_cleared");
    add(8,  24, K_SIG, 1, 32'h0,    "irq_cleared");
    add(9,  20, K_RDC, 3, 32'd7,    "white_count7");
    add(9,  20, K_RDC, 1, 32'h5,    "frame_done_set");
    add(9,  20, K_SIG, 1, 32'h1,    "irq_rise");
    add(9,  21, K_WR,  1, 32'h4,    "");
    add(9,  24, K_SIG, 1, 32'h0,    "irq_drop");
    add(10, 15, K_WR,  1, 32'h4,    "");
    add(10, 18, K_RDC, 1, 32'h5,    "w1c_vs_sof");
    add(10, 20, K_SIG, 1, 32'h1,    "irq_w1c_vs_sof");
    add(11, 20, K_RST, 0, 32'h0,    "");
    add(12, 20, K_RDC, 2, 32'd0,    "fcount_first_sof");
    add(12, 20, K_RDC, 1, 32'h0,    "status_post_reset");
    add(13, 20, K_RDC, 2, 32'd1,    "fcount_second_sof");

    cam_en_in = 1'b0; cam_hs_in = '0; cam_pix_in = '0; data_in = '0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      avs_address = 2'(a); #1;
      chk("reset_reg", avs_readdata, 32'h0);
    end
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_dout", {16'b0, data_out}, 32'h0);
    reset = 1'b0;

    for (int f = 0; f < 14; f++) begin
      foreach (dir_tab[i]) if (dir_tab[i].frame == f) ops.push_back(dir_tab[i]);
      frame(kinds[f]);
    end

    // CTRL writes stay well clear of the delayed start-of-frame so request timing is unambiguous.
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) add_rand(3,  K_WR, 0, 32'($urandom_range(0, 3)), "");
      if ($urandom_range(0, 1) == 1) add_rand(22, K_WR, 0, 32'($urandom_range(0, 3)), "");
      if ($urandom_range(0, 1) == 1) add_rand($urandom_range(11, 21), K_WR, 1, 32'h4, "");
      if ($urandom_range(0, 3) == 0) add_rand(24, K_WR, 2, $urandom, "");
      add_rand(10, K_RDM, 0, 32'h0, "rand_ctrl");
      add_rand(10, K_RDM, 1, 32'h0, "rand_status");
      add_rand(26, K_RDM, 2, 32'h0, "rand_fcount");
      add_rand(26, K_RDM, 3, 32'h0, "rand_wcount");
      frame(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/median_filter_ctrl.md
Name: median_filter_ctrl

Overview:
Controller that sequences the 1x15 median filter stage of the camera pipeline and exposes it on Avalon-MM. It forwards camera pixels to the filter and builds a matched-latency bypass path. It selects filtered or bypass output, and applies mode changes only at start of frame. It also counts frames and white pixels, and raises a per-frame interrupt.

Parameters:
LATENCY, 15, median stage delay in clocks; bypass path delay must equal it
HSYNC_W, 10, line counter width
PIX_W, 11, pixel counter width

Ports:
clk  in  1  pixel clock; all sequential logic on falling edge, same as camera pipeline
reset  in  1  asynchronous, active-high
avs_address  in  2  register select
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, combinational from avs_address (0 wait states)
irq  out  1  frame-done interrupt
Cam_enable_in  in  1  camera pixel valid
CamHsync_count_in  in  HSYNC_W  camera line index
CamPix_count_in  in  PIX_W  camera pixel index
data_in  in  16  camera pixel
med_data_in  out  16  to median stage; equals data_in (combinational)
med_enable_out  in  1  median stage delayed valid
med_hsync_out  in  HSYNC_W  median stage delayed line index
med_pix_out  in  PIX_W  median stage delayed pixel index
med_data_out  in  16  median stage result (16'hffff or 16'h0000)
Cam_enable_out  out  1  output valid = med_enable_out
CamHsync_count_out  out  HSYNC_W  = med_hsync_out
CamPix_count_out  out  PIX_W  = med_pix_out
data_out  out  16  selected pixel

Behaviour:
- Bypass path: LATENCY-deep 16-bit shift register of data_in. Reset clears it to 0. data_out = ON-family state ? med_data_out : bypass tap. Both paths are time-aligned.
- sof = med_enable_out & med_hsync_out==0 & med_pix_out==0. Sampled on delayed side.
- Registers:
  - 0 CTRL (R/W): bit0 FILTER_EN_REQ, bit1 IRQ_EN. Reset 0.
  - 1 STATUS: bit0 FILTER_ACTIVE (RO), bit1 CHANGE_PENDING (RO), bit2 FRAME_DONE (sticky; write 1 clears). Reset 0.
  - 2 FRAME_COUNT (RO, 16b zero-extended): wraps 16'hffff->0. Any write clears it.
  - 3 WHITE_COUNT (RO, 21b zero-extended): white pixels of last completed frame.
- FSM states: OFF (reset), ARM_ON, ON, ARM_OFF.
  - OFF: FILTER_EN_REQ=1 -> ARM_ON.
  - ARM_ON: sof -> ON; FILTER_EN_REQ=0 before sof -> OFF.
  - ON: FILTER_EN_REQ=0 -> ARM_OFF.
  - ARM_OFF: sof -> OFF; FILTER_EN_REQ=1 before sof -> ON.
- Output select: ON and ARM_OFF select filter; OFF and ARM_ON select bypass. The switch takes effect on the sof pixel itself, because the next state is used for the mux on the sof cycle.
- FILTER_ACTIVE = state in {ON, ARM_OFF}. CHANGE_PENDING = state in {ARM_ON, ARM_OFF}.
- Pixel counter (21b): increments on each Cam_enable_out with data_out==16'hffff.
- Frame handling on each sof:
  - On the first sof after reset, only seen_frame is set.
  - On later sofs: WHITE_COUNT latches the count; FRAME_COUNT++; FRAME_DONE set.
  - On every sof the pixel counter restarts. The sof pixel counts toward the new frame (counter loads 1 if white, else 0).
- Write-1-clear of FRAME_DONE in the same cycle as a set: the set wins.
- irq = FRAME_DONE & IRQ_EN, registered.
- Writes take effect on the falling edge with avs_write high. Reads have no side effects.
- Reset mid-frame: all state, counters and the bypass pipe return to 0/OFF immediately. The frame after reset is not reported.

Test Plan:
- Reset, no writes, stream 3 frames of 4x4 with data_in=16'h1234 -> data_out=16'h1234 exactly 15 clocks after input, FRAME_COUNT=2, FILTER_ACTIVE=0.
- Write CTRL=1 mid-frame -> STATUS=2'b10 until next sof, then data_out follows med_data_out from the sof pixel onward, STATUS bit0=1.
- Write CTRL=1 then CTRL=0 before sof -> state returns to OFF, no switch at sof, CHANGE_PENDING=0.
- Filter on, frame with 7 white outputs -> at next sof WHITE_COUNT=7, FRAME_DONE=1. With IRQ_EN=1, irq rises; write STATUS=4 -> irq drops.
- Write-1-clear of FRAME_DONE coincident with sof -> FRAME_DONE stays 1.
- Assert reset mid-frame with filter ON -> all outputs, registers and irq go to 0 asynchronously; first subsequent sof does not increment FRAME_COUNT.
